// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and general register file.
//
// Takes the MEM/WB bundle, decodes the destination register and the writeback
// source, and commits the result into a 32x32 register file. Two combinational
// read ports for decode pass a write from the same cycle straight through. The
// committed write goes to the hazard/forwarding unit. Two counters track retired
// instructions and committed writes for trace and debug.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous, active-low; clears the registers and counters
//   IR_W       W-stage instruction
//   PC8_W      PC+8 of the W-stage instruction (link value)
//   AO_W       ALU result
//   DR_W       load data from data memory
//   WriteEn_W  write enable from the MEM/WB register
//   A1, A2     read addresses
//   RD1, RD2   read data (combinational, with same-cycle write bypass)
//   WbAddr     effective destination this cycle, 0 when nothing commits
//   WbData     selected writeback data
//   WbEn       a register commits at the next rising edge
//   RetireCnt  number of nonzero IRs retired (wraps)
//   WriteCnt   number of committed register writes (wraps)

module wb_regfile #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         IR_W,
    input  logic [31:0]         PC8_W,
    input  logic [31:0]         AO_W,
    input  logic [31:0]         DR_W,
    input  logic                WriteEn_W,
    input  logic [4:0]          A1,
    input  logic [4:0]          A2,
    output logic [31:0]         RD1,
    output logic [31:0]         RD2,
    output logic [4:0]          WbAddr,
    output logic [31:0]         WbData,
    output logic                WbEn,
    output logic [RETIRE_W-1:0] RetireCnt,
    output logic [RETIRE_W-1:0] WriteCnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_MEM,
        SRC_LINK
    } wb_src_e;

    logic [31:0]         regs_q [32];
    logic [RETIRE_W-1:0] retire_q, retire_d;
    logic [RETIRE_W-1:0] write_q, write_d;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       has_dest;
    logic [4:0] dest;
    wb_src_e    src;
    logic       wb_en;

    // rs, shamt and the upper immediate bits play no part in writeback.
    logic unused_ir;
    assign unused_ir = ^{IR_W[25:21], IR_W[10:6]};

    assign op    = IR_W[31:26];
    assign funct = IR_W[5:0];
    assign rt    = IR_W[20:16];
    assign rd    = IR_W[15:11];

    // Destination and source decode. Anything without a destination (sw,
    // branches, j, jr, unknown opcodes) falls back to the ALU source so that
    // WbData stays deterministic.
    always_comb begin
        has_dest = 1'b0;
        dest     = 5'd0;
        src      = SRC_ALU;
        unique case (op)
            OP_RTYPE: begin
                if (funct == FN_JALR) begin
                    has_dest = 1'b1;
                    dest     = rd;
                    src      = SRC_LINK;
                end else if (funct != FN_JR) begin
                    has_dest = 1'b1;
                    dest     = rd;
                end
            end
            OP_ADDIU, OP_ORI, OP_LUI: begin
                has_dest = 1'b1;
                dest     = rt;
            end
            OP_LW: begin
                has_dest = 1'b1;
                dest     = rt;
                src      = SRC_MEM;
            end
            OP_JAL: begin
                has_dest = 1'b1;
                dest     = 5'd31;
                src      = SRC_LINK;
            end
            default: ;
        endcase
    end

    // A bubble decodes as rd=0, so it can never commit. Holding reset low
    // also blocks commit and disables the bypass.
    assign wb_en = reset & WriteEn_W & has_dest & (dest != 5'd0);

    always_comb begin
        case (src)
            SRC_MEM:  WbData = DR_W;
            SRC_LINK: WbData = PC8_W;
            default:  WbData = AO_W;
        endcase
    end

    assign WbEn   = wb_en;
    assign WbAddr = wb_en ? dest : 5'd0;

    // Read ports: $0 is hard zero. The bypass makes a write visible in the
    // cycle it is presented, before it reaches the array.
    assign RD1 = (!reset || A1 == 5'd0)  ? 32'd0  :
                 (wb_en && A1 == WbAddr) ? WbData : regs_q[A1];
    assign RD2 = (!reset || A2 == 5'd0)  ? 32'd0  :
                 (wb_en && A2 == WbAddr) ? WbData : regs_q[A2];

    always_comb begin
        retire_d = retire_q;
        write_d  = write_q;
        if (IR_W != 32'd0) retire_d = retire_q + RETIRE_W'(1);
        if (wb_en)         write_d  = write_q + RETIRE_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
            retire_q <= '0;
            write_q  <= '0;
        end else begin
            if (wb_en) regs_q[WbAddr] <= WbData;
            retire_q <= retire_d;
            write_q  <= write_d;
        end
    end

    assign RetireCnt = retire_q;
    assign WriteCnt  = write_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] IR_W, PC8_W, AO_W, DR_W;
    logic        WriteEn_W;
    logic [4:0]  A1, A2;

    logic [31:0] RD1, RD2, WbData;
    logic [4:0]  WbAddr;
    logic        WbEn;
    logic [31:0] RetireCnt, WriteCnt;

    logic [31:0] RD1_4, RD2_4, WbData_4;
    logic [4:0]  WbAddr_4;
    logic        WbEn_4;
    logic [3:0]  RetireCnt_4, WriteCnt_4;

    int n_vec = 0;
    int n_err = 0;

    wb_regfile #(.RETIRE_W(32)) u_dut (
        .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W),
        .DR_W(DR_W), .WriteEn_W(WriteEn_W), .A1(A1), .A2(A2),
        .RD1(RD1), .RD2(RD2), .WbAddr(WbAddr), .WbData(WbData), .WbEn(WbEn),
        .RetireCnt(RetireCnt), .WriteCnt(WriteCnt)
    );

    wb_regfile #(.RETIRE_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W),
        .DR_W(DR_W), .WriteEn_W(WriteEn_W), .A1(A1), .A2(A2),
        .RD1(RD1_4), .RD2(RD2_4), .WbAddr(WbAddr_4), .WbData(WbData_4), .WbEn(WbEn_4),
        .RetireCnt(RetireCnt_4), .WriteCnt(WriteCnt_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc8;
        logic [31:0] ao;
        logic [31:0] dr;
        logic        we;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  wbaddr;
        logic        wben;
        logic [31:0] wbdata;
        logic [31:0] ret;
        logic [31:0] wr;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(
        logic [31:0] ir, logic [31:0] pc8, logic [31:0] ao, logic [31:0] dr,
        logic we, logic [4:0] a1, logic [4:0] a2,
        logic [31:0] rd1, logic [31:0] rd2, logic [4:0] wbaddr, logic wben,
        logic [31:0] wbdata, logic [31:0] ret, logic [31:0] wr);
        vec_t v;
        v.ir = ir; v.pc8 = pc8; v.ao = ao; v.dr = dr; v.we = we;
        v.a1 = a1; v.a2 = a2; v.rd1 = rd1; v.rd2 = rd2; v.wbaddr = wbaddr;
        v.wben = wben; v.wbdata = wbdata; v.ret = ret; v.wr = wr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc8, input logic [31:0] ao,
                         input logic [31:0] dr, input logic we, input logic [4:0] a1,
                         input logic [4:0] a2);
        IR_W = ir; PC8_W = pc8; AO_W = ao; DR_W = dr; WriteEn_W = we; A1 = a1; A2 = a2;
    endtask

    initial begin
        // addu $3,$1,$2 ; bubble ; lw $8 ; jal ; ori $0 ; sw ; jalr $5,$31 ;
        // jr $31 ; addiu $9 with WriteEn_W=0 ; lui $9 ; idle
        tbl[0]  = mk(32'h00221821, 32'h0,    32'h1234,     32'h0,        1'b1, 5'd3,  5'd0,
                     32'h1234,     32'h0,        5'd3,  1'b1, 32'h1234,     32'd0, 32'd0);
        tbl[1]  = mk(32'h00000000, 32'h0,    32'h5555,     32'h0,        1'b1, 5'd3,  5'd8,
                     32'h1234,     32'h0,        5'd0,  1'b0, 32'h5555,     32'd1, 32'd1);
        tbl[2]  = mk(32'h8C080000, 32'h0,    32'h4,        32'hDEADBEEF, 1'b1, 5'd8,  5'd3,
                     32'hDEADBEEF, 32'h1234,     5'd8,  1'b1, 32'hDEADBEEF, 32'd1, 32'd1);
        tbl[3]  = mk(32'h0C000010, 32'h3008, 32'h77,       32'h0,        1'b1, 5'd31, 5'd8,
                     32'h3008,     32'hDEADBEEF, 5'd31, 1'b1, 32'h3008,     32'd2, 32'd2);
        tbl[4]  = mk(32'h34000005, 32'h0,    32'h5,        32'h0,        1'b1, 5'd0,  5'd31,
                     32'h0,        32'h3008,     5'd0,  1'b0, 32'h5,        32'd3, 32'd3);
        tbl[5]  = mk(32'hAC080000, 32'h0,    32'h10,       32'h99,       1'b1, 5'd8,  5'd31,
                     32'hDEADBEEF, 32'h3008,     5'd0,  1'b0, 32'h10,       32'd4, 32'd3);
        tbl[6]  = mk(32'h03E02809, 32'h4008, 32'hAAAA,     32'h0,        1'b1, 5'd5,  5'd0,
                     32'h4008,     32'h0,        5'd5,  1'b1, 32'h4008,     32'd5, 32'd3);
        tbl[7]  = mk(32'h03E00008, 32'h5000, 32'hBBBB,     32'h0,        1'b1, 5'd5,  5'd31,
                     32'h4008,     32'h3008,     5'd0,  1'b0, 32'hBBBB,     32'd6, 32'd4);
        tbl[8]  = mk(32'h24090007, 32'h0,    32'h7,        32'h0,        1'b0, 5'd9,  5'd0,
                     32'h0,        32'h0,        5'd0,  1'b0, 32'h7,        32'd7, 32'd4);
        tbl[9]  = mk(32'h3C09ABCD, 32'h0,    32'hABCD0000, 32'h0,        1'b1, 5'd9,  5'd9,
                     32'hABCD0000, 32'hABCD0000, 5'd9,  1'b1, 32'hABCD0000, 32'd8, 32'd4);
        tbl[10] = mk(32'h00000000, 32'h0,    32'h0,        32'h0,        1'b0, 5'd9,  5'd5,
                     32'hABCD0000, 32'h4008,     5'd0,  1'b0, 32'h0,        32'd9, 32'd5);

        // Reset held low from time 0
        reset = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd31);
        #2;
        chk("reset_rd1", RD1, 32'h0);
        chk("reset_wben", {31'b0, WbEn}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_reset_rd1", RD1, 32'h0);
        chk("post_reset_rd2", RD2, 32'h0);
        chk("post_reset_retire", RetireCnt, 32'h0);
        chk("post_reset_write", WriteCnt, 32'h0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].ir, tbl[i].pc8, tbl[i].ao, tbl[i].dr, tbl[i].we, tbl[i].a1, tbl[i].a2);
            #1;
            chk($sformatf("v%0d_rd1", i), RD1, tbl[i].rd1);
            chk($sformatf("v%0d_rd2", i), RD2, tbl[i].rd2);
            chk($sformatf("v%0d_wbaddr", i), {27'b0, WbAddr}, {27'b0, tbl[i].wbaddr});
            chk($sformatf("v%0d_wben", i), {31'b0, WbEn}, {31'b0, tbl[i].wben});
            chk($sformatf("v%0d_wbdata", i), WbData, tbl[i].wbdata);
            chk($sformatf("v%0d_retire", i), RetireCnt, tbl[i].ret);
            chk($sformatf("v%0d_write", i), WriteCnt, tbl[i].wr);
        end

        // Array contents after the table, read back with no write pending
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd31);
        #1;
        chk("arr_r3", RD1, 32'h1234);
        chk("arr_r31", RD2, 32'h3008);
        chk("final_retire", RetireCnt, 32'd9);
        chk("final_write", WriteCnt, 32'd5);
        chk("final_retire4", {28'b0, RetireCnt_4}, 32'd9);
        A1 = 5'd8; A2 = 5'd5;
        #1;
        chk("arr_r8", RD1, 32'hDEADBEEF);
        chk("arr_r5", RD2, 32'h4008);

        // Asynchronous clear between edges
        A1 = 5'd3; A2 = 5'd9;
        #1;
        reset = 1'b0;
        #1;
        chk("async_rd1", RD1, 32'h0);
        chk("async_rd2", RD2, 32'h0);
        chk("async_retire", RetireCnt, 32'h0);
        chk("async_write", WriteCnt, 32'h0);

        // A write presented across an edge while reset is low is discarded
        @(negedge clk);
        drive(32'h00221821, 32'h0, 32'h9999, 32'h0, 1'b1, 5'd3, 5'd0);
        #1;
        chk("rst_wben", {31'b0, WbEn}, 32'h0);
        chk("rst_wbaddr", {27'b0, WbAddr}, 32'h0);
        chk("rst_rd1", RD1, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd0);
        #1;
        chk("rst_discard_r3", RD1, 32'h0);
        chk("rst_discard_retire", RetireCnt, 32'h0);

        // First edge after release behaves normally
        @(negedge clk);
        drive(32'h00221821, 32'h0, 32'h4321, 32'h0, 1'b1, 5'd3, 5'd0);
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd0);
        #1;
        chk("rel_r3", RD1, 32'h4321);
        chk("rel_retire", RetireCnt, 32'd1);
        chk("rel_write", WriteCnt, 32'd1);

        // Counter wrap on the 4-bit instance
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(32'hAC080000, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        for (int k = 0; k < 15; k++) @(negedge clk);
        #1;
        chk("wrap4_15", {28'b0, RetireCnt_4}, 32'hF);
        @(negedge clk);
        IR_W = 32'h0;
        #1;
        chk("wrap4_16", {28'b0, RetireCnt_4}, 32'h0);
        chk("wrap32_16", RetireCnt, 32'd16);
        chk("wrap_write", WriteCnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register. Takes the latched writeback bundle (IR, PC+8, ALU result, load data, write enable), decodes the destination register and writeback source, and commits the result into a 32x32 general register file.
- Provides the two decode-stage read ports with same-cycle write bypass.
- Exposes the committed write to the hazard/forwarding unit.
- Keeps retirement counters for trace and debug.

Parameters:
- RETIRE_W, 32, width of the retire and write counters (wrap modulo 2^RETIRE_W).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- IR_W  in  32  instruction in the W stage.
- PC8_W  in  32  PC+8 of the W-stage instruction.
- AO_W  in  32  ALU result.
- DR_W  in  32  load data from data memory.
- WriteEn_W  in  1  write enable from the MEM/WB register (already forced to 0 for a zero IR).
- A1  in  5  read address, port 1.
- A2  in  5  read address, port 2.
- RD1  out  32  read data, port 1 (combinational).
- RD2  out  32  read data, port 2 (combinational).
- WbAddr  out  5  effective destination this cycle; 0 when no write.
- WbData  out  32  selected writeback data.
- WbEn  out  1  a register commits at the next edge.
- RetireCnt  out  RETIRE_W  count of nonzero IRs retired.
- WriteCnt  out  RETIRE_W  count of committed register writes.

Behaviour:
- Decode of op=IR[31:26], funct=IR[5:0], rs/rt/rd as usual:
  - op=0, funct not 0x08 (jr), not 0x09 (jalr): dest=rd, data=AO_W.
  - op=0, funct=0x09 (jalr): dest=rd, data=PC8_W.
  - op=0x09 (addiu), 0x0D (ori), 0x0F (lui): dest=rt, data=AO_W.
  - op=0x23 (lw): dest=rt, data=DR_W.
  - op=0x03 (jal): dest=31, data=PC8_W.
  - All other opcodes (sw, beq, j, jr, unknown): no destination.
- WbEn = WriteEn_W AND decoded destination exists AND dest != 0.
- WbAddr = dest when WbEn, else 0. WbData = selected data (don't-care when WbEn=0, but deterministic).
- Commit: at the rising edge with WbEn=1, regs[WbAddr] <= WbData. regs[0] is never written.
- Reads:
  - RDn = 0 if An == 0.
  - Else RDn = WbData if WbEn and An == WbAddr (write-through bypass, same cycle).
  - Else RDn = regs[An].
- Counters, at each rising edge:
  - RetireCnt increments if IR_W != 0.
  - WriteCnt increments if WbEn.
  - Both wrap to 0 after all-ones.
  - A single instruction may increment both counters in the same cycle.
- Reset (reset=0, asynchronous):
  - All 32 registers, RetireCnt and WriteCnt go to 0 at once, without waiting for a clock edge.
  - While reset=0, WbEn is forced 0, so WbAddr=0. RD1 and RD2 read 0 for every address, because the registers are cleared and the bypass is disabled.
- Reset mid-operation: a write whose edge coincides with reset low is discarded. After reset deasserts, the first edge behaves normally. The reset release is synchronised externally.
- IR_W=0 (bubble): no write and no retire increment, even if WriteEn_W=1.
- Latency: write visible through the bypass in the same cycle, and from the array from the next cycle on.

Test Plan:
- Reset release, then read A1=5, A2=31 -> RD1=0, RD2=0, RetireCnt=0, WriteCnt=0.
- Asynchronous clear: load regs[3]=0x1234, pull reset low between edges -> RD with A1=3 reads 0 immediately; both counters are 0.
- addu $3,$1,$2 (IR=0x00221821), AO_W=0x1234, WriteEn_W=1:
  - With A1=3 in the same cycle -> RD1=0x1234 (bypass), WbAddr=3.
  - After the edge, RD1=0x1234; RetireCnt=1, WriteCnt=1.
- lw $8,0($0) (IR=0x8C080000), DR_W=0xDEADBEEF, AO_W=0x4 -> regs[8]=0xDEADBEEF. Then jal (IR=0x0C000010), PC8_W=0x3008 -> regs[31]=0x3008.
- Writes to $0: ori $0,$0,5 (IR=0x34000005), WriteEn_W=1 -> WbEn=0, RD1 with A1=0 reads 0, RetireCnt increments, WriteCnt unchanged.
  - Then sw (IR=0xAC080000) -> no register change, RetireCnt+1.
- Bubble: IR_W=0 with WriteEn_W=1 -> no write, no counter change.
- Wrap: RETIRE_W=4, retire 16 nonzero-IR instructions -> RetireCnt returns to 0.
